md5_pw_control_p: RTL and testbench
===================================

Name: md5_pw_control_p

Overview:
- Parametrised successor to the single-password MD5 control block.
- Accepts a password as a valid/ready byte stream with a last marker, and builds one MD5-padded 512-bit block.
- Launches an external MD5 core, compares its digest to a stored reference digest, and reports match/fail.
- Adds attempt counting, a configurable lockout period after repeated failures, and overlength rejection.

Parameters:
- MAX_LEN, 55: maximum password length in bytes, legal range 1..55 (single MD5 block).
- MAX_FAIL, 3: consecutive failures that trigger lockout, range 1..15.
- LOCK_CYCLES, 1000: lockout duration in clocks, minimum 1.
- CNT_W, 16: lockout counter width; must satisfy 2^CNT_W > LOCK_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- s_axis_tdata  in  8  password byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tlast  in  1  final byte of the password.
- s_axis_ready  out  1  block accepts a byte this cycle.
- ref_digest  in  128  stored digest; byte 0 of the digest is [127:120]; must be stable while busy.
- md5_block  out  512  padded block; message byte i is at [8i+7:8i].
- md5_start  out  1  one-cycle start pulse to the MD5 core.
- md5_done  in  1  one-cycle pulse; md5_digest is valid in the same cycle.
- md5_digest  in  128  digest, same byte order as ref_digest.
- m_axis_tdata  out  1  result: 1 = match, 0 = fail.
- m_axis_tvalid  out  1  result valid; held until m_axis_tready.
- m_axis_tready  in  1  downstream accepts the result.
- locked  out  1  lockout is active.
- fail_cnt  out  4  consecutive-failure count.
- out  out  4  state code for debug and LEDs.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - All outputs clear to 0, md5_block included, except `out`, which equals the IDLE code.
  - Length, overflow flag and fail_cnt clear to 0.
  - Reset mid-operation aborts the attempt. A later md5_done is ignored unless the block is in WAIT.
- State codes on `out`: IDLE=0, COLLECT=1, LAUNCH=2, WAIT=3, CMP=4, RESULT=5, LOCKED=6.
- IDLE:
  - s_axis_ready=1.
  - A transfer (tvalid & ready) writes the byte to index 0 and sets len=1.
  - If tlast is set on that byte, go to LAUNCH; otherwise go to COLLECT.
  - Clear the 512-bit buffer in the cycle the first byte is accepted.
- COLLECT:
  - s_axis_ready=1.
  - Each transfer writes byte[len] and increments len.
  - Once len reaches MAX_LEN, further bytes are dropped and the overflow flag is set; ready stays 1 so the stream drains.
  - A transfer with tlast goes to LAUNCH, or to CMP with a forced fail if overflow is set.
- LAUNCH (1 cycle):
  - Write byte[len]=0x80.
  - Write bytes 56..63 = len*8 as a 64-bit little-endian value.
  - All other bytes stay 0.
  - Assert md5_start for exactly this cycle, with md5_block already final.
  - Go to WAIT.
- WAIT:
  - s_axis_ready=0.
  - On md5_done, register (md5_digest == ref_digest) and go to CMP.
  - No timeout.
- CMP (1 cycle):
  - Match: fail_cnt becomes 0.
  - Fail: fail_cnt increments, saturating at 15.
  - Set m_axis_tdata to the result and m_axis_tvalid=1, then go to RESULT.
- RESULT:
  - Hold m_axis_tdata and m_axis_tvalid until m_axis_tready=1.
  - On the handshake cycle: if fail_cnt >= MAX_FAIL, go to LOCKED and load the counter with LOCK_CYCLES-1; otherwise go to IDLE.
  - tvalid drops the cycle after the handshake.
- LOCKED:
  - locked=1 and s_axis_ready=0.
  - The counter decrements each cycle. At 0, go to IDLE, clear locked and clear fail_cnt.
- Latency: the result is valid 1 cycle after md5_done (the CMP edge).
  - Overlength path: the result is valid 1 cycle after the tlast transfer.
- s_axis_ready is driven combinationally from state only, never from tvalid.
- Zero-length passwords are not representable; the first accepted byte always counts.

Test Plan:
- "abc" (0x61,0x62,0x63, tlast on 0x63) with ref_digest=900150983cd24fb0d6963f7d28e17f72 and a bench MD5 model:
  - md5_block bytes 0..3 are 61 62 63 80; byte 56=0x18; all other bytes 0.
  - md5_start pulses once; m_axis_tdata=1; fail_cnt=0.
- Single byte 0x61 with tlast, ref_digest=0:
  - byte1=0x80, byte56=0x08; result 0; fail_cnt=1.
- Three consecutive wrong attempts with MAX_FAIL=3, LOCK_CYCLES=10:
  - After the third result handshake, locked=1 and s_axis_ready=0 for exactly 10 cycles.
  - Then IDLE, with fail_cnt=0 and ready=1.
- 60-byte stream with MAX_LEN=55:
  - All 60 bytes are accepted (ready held 1) and md5_start never pulses.
  - Result 0 appears 1 cycle after tlast; fail_cnt increments.
- Backpressure: hold m_axis_tready=0 for 5 cycles after the result.
  - tvalid and tdata stay stable and s_axis_ready=0.
  - Release: a single handshake, then the block returns to IDLE.
- Reset asserted during WAIT, then a md5_done pulse after release:
  - Block is in IDLE with all outputs 0; no result is produced.

Source files
------------

// File: rtl/md5_pw_control_p.sv
// Password check front-end for an external MD5 core: collects a byte stream into one
// padded MD5 block, compares the returned digest, and applies failure lockout.
module md5_pw_control_p #(
    parameter int MAX_LEN     = 55,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   s_axis_tdata,
    input  logic         s_axis_tvalid,
    input  logic         s_axis_tlast,
    output logic         s_axis_ready,
    input  logic [127:0] ref_digest,
    output logic [511:0] md5_block,
    output logic         md5_start,
    input  logic         md5_done,
    input  logic [127:0] md5_digest,
    output logic         m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         locked,
    output logic [3:0]   fail_cnt,
    output logic [3:0]   out
);

    localparam int LEN_W = 6;
    localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_LEN);
    localparam logic [3:0]       MAX_FAIL_C = 4'(MAX_FAIL);
    localparam logic [CNT_W-1:0] LOCK_C     = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_LAUNCH  = 3'd2,
        S_WAIT    = 3'd3,
        S_CMP     = 3'd4,
        S_RESULT  = 3'd5,
        S_LOCKED  = 3'd6
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;
    logic               match_q;
    logic [511:0]       block_q;
    logic               start_q;
    logic               tdata_q;
    logic               tvalid_q;
    logic               locked_q;
    logic [3:0]         fail_cnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   len_d;
    logic [LEN_W+2:0]   bitlen_d;

    // Length after accepting the current byte, and its value in bits for the length field.
    always_comb begin
        len_d    = len_q + 6'd1;
        bitlen_d = {len_d, 3'b000};
    end

    // Control FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= 6'd0;
            ovf_q      <= 1'b0;
            match_q    <= 1'b0;
            block_q    <= 512'd0;
            start_q    <= 1'b0;
            tdata_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            locked_q   <= 1'b0;
            fail_cnt_q <= 4'd0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (s_axis_tvalid) begin
                        block_q       <= 512'd0;
                        block_q[7:0]  <= s_axis_tdata;
                        len_q         <= 6'd1;
                        ovf_q         <= 1'b0;
                        if (s_axis_tlast) begin
                            // Single-byte password: pad and length can be laid down right away.
                            block_q[15:8]    <= 8'h80;
                            block_q[511:448] <= 64'd8;
                            start_q          <= 1'b1;
                            state_q          <= S_LAUNCH;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (s_axis_tvalid) begin
                        if (len_q < MAX_LEN_C) begin
                            block_q[{len_q, 3'b000} +: 8] <= s_axis_tdata;
                            len_q                         <= len_d;
                            if (s_axis_tlast) begin
                                block_q[{len_d, 3'b000} +: 8] <= 8'h80;
                                block_q[511:448]              <= {55'd0, bitlen_d};
                                start_q                       <= 1'b1;
                                state_q                       <= S_LAUNCH;
                            end
                        end else begin
                            // Overlength bytes are drained so the stream never stalls.
                            ovf_q <= 1'b1;
                            if (s_axis_tlast) begin
                                match_q <= 1'b0;
                                state_q <= S_CMP;
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (md5_done) begin
                        match_q <= (md5_digest == ref_digest);
                        state_q <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (match_q) begin
                        fail_cnt_q <= 4'd0;
                    end else if (fail_cnt_q != 4'd15) begin
                        fail_cnt_q <= fail_cnt_q + 4'd1;
                    end
                    tdata_q  <= match_q;
                    tvalid_q <= 1'b1;
                    state_q  <= S_RESULT;
                end
                S_RESULT: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        tdata_q  <= 1'b0;
                        if (fail_cnt_q >= MAX_FAIL_C) begin
                            locked_q <= 1'b1;
                            cnt_q    <= LOCK_C;
                            state_q  <= S_LOCKED;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_LOCKED: begin
                    if (cnt_q == '0) begin
                        locked_q   <= 1'b0;
                        fail_cnt_q <= 4'd0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis_ready  = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign md5_block     = block_q;
    assign md5_start     = start_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign locked        = locked_q;
    assign fail_cnt      = fail_cnt_q;
    assign out           = {1'b0, state_q};

endmodule

// File: tb/tb_md5_pw_control_p.sv
// Randomized self-checking bench for md5_pw_control_p with an in-bench MD5 model
// acting both as the external core and as the reference for expected results.
module tb_md5_pw_control_p;

    localparam int MAX_LEN     = 55;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 10;

    typedef logic [7:0] bytes_t[$];

    logic         clk;
    logic         reset;
    logic [7:0]   s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_ready;
    logic [127:0] ref_digest;
    logic [511:0] md5_block;
    logic         md5_start;
    logic         md5_done;
    logic [127:0] md5_digest;
    logic         m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         locked;
    logic [3:0]   fail_cnt;
    logic [3:0]   out;

    int n_chk  = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int model_fail = 0;
    logic [31:0] k_tab[64];
    int sh_tab[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    md5_pw_control_p #(
        .MAX_LEN(MAX_LEN), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_ready(s_axis_ready),
        .ref_digest(ref_digest), .md5_block(md5_block), .md5_start(md5_start),
        .md5_done(md5_done), .md5_digest(md5_digest),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .locked(locked), .fail_cnt(fail_cnt), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses mid-cycle, away from the edge that changes them.
    always @(negedge clk) if (md5_start) start_cnt++;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] md5_calc(input logic [511:0] blk);
        logic [31:0] a, b, c, d, f;
        logic [31:0] m[16];
        int g, s;
        for (int j = 0; j < 16; j++) m[j] = blk[32*j +: 32];
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i;                end
                1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16;     end
            endcase
            s = sh_tab[(i / 16) * 4 + (i % 4)];
            f = f + a + k_tab[i] + m[g];
            a = d; d = c; c = b;
            b = b + ((f << s) | (f >> (32 - s)));
        end
        a = a + 32'h67452301; b = b + 32'hefcdab89;
        c = c + 32'h98badcfe; d = d + 32'h10325476;
        return {bswap(a), bswap(b), bswap(c), bswap(d)};
    endfunction

    // Standard MD5 padding of a message that fits one block.
    function automatic logic [511:0] pad_block(input bytes_t pw);
        logic [511:0] r;
        int n;
        n = pw.size();
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = pw[i];
        r[8*n +: 8] = 8'h80;
        r[511:448] = 64'(n * 8);
        return r;
    endfunction

    // One full password attempt; want = -1 derives the expected result from the model.
    task automatic run_attempt(input bytes_t pw, input logic [127:0] refd, input int bp,
                               input int want, input string tag);
        logic exp_ovf, exp_match;
        int starts0, dly;
        exp_ovf = (pw.size() > MAX_LEN);
        if (want >= 0) exp_match = want[0];
        else exp_match = !exp_ovf && (md5_calc(pad_block(pw)) == refd);
        ref_digest = refd;
        starts0 = start_cnt;
        for (int i = 0; i < pw.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                tick();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pw[i];
            s_axis_tlast  = (i == pw.size() - 1);
            check_eq({tag, "_ready_in"}, s_axis_ready, 1'b1);
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!exp_ovf) begin
            check_eq({tag, "_start"}, md5_start, 1'b1);
            check_eq({tag, "_block"}, md5_block, pad_block(pw));
            tick();
            check_eq({tag, "_wait_state"}, out, 4'd3);
            check_eq({tag, "_wait_ready"}, s_axis_ready, 1'b0);
            dly = $urandom_range(0, 3);
            for (int i = 0; i < dly; i++) tick();
            md5_digest = md5_calc(md5_block);
            md5_done = 1'b1;
            tick();
            md5_done = 1'b0;
        end
        check_eq({tag, "_cmp_state"}, out, 4'd4);
        check_eq({tag, "_cmp_tvalid"}, m_axis_tvalid, 1'b0);
        tick();
        if (exp_match) model_fail = 0;
        else if (model_fail < 15) model_fail++;
        check_eq({tag, "_tvalid"}, m_axis_tvalid, 1'b1);
        check_eq({tag, "_tdata"}, m_axis_tdata, exp_match);
        check_eq({tag, "_fail_cnt"}, fail_cnt, 4'(model_fail));
        check_eq({tag, "_starts"}, start_cnt - starts0, exp_ovf ? 0 : 1);
        for (int j = 0; j < bp; j++) begin
            tick();
            check_eq({tag, "_bp_tvalid"}, m_axis_tvalid, 1'b1);
            check_eq({tag, "_bp_tdata"}, m_axis_tdata, exp_match);
            check_eq({tag, "_bp_ready"}, s_axis_ready, 1'b0);
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        check_eq({tag, "_tvalid_drop"}, m_axis_tvalid, 1'b0);
        if (model_fail >= MAX_FAIL) begin
            for (int i = 0; i < LOCK_CYCLES; i++) begin
                check_eq({tag, "_locked"}, locked, 1'b1);
                check_eq({tag, "_lock_ready"}, s_axis_ready, 1'b0);
                tick();
            end
            model_fail = 0;
            check_eq({tag, "_unlocked"}, locked, 1'b0);
        end
        check_eq({tag, "_idle_state"}, out, 4'd0);
        check_eq({tag, "_idle_ready"}, s_axis_ready, 1'b1);
        check_eq({tag, "_idle_fail_cnt"}, fail_cnt, 4'(model_fail));
    endtask

    initial begin
        bytes_t pw;
        logic [127:0] refd;
        int n;
        real x;
        for (int i = 0; i < 64; i++) begin
            x = $sin(real'(i + 1));
            if (x < 0.0) x = -x;
            k_tab[i] = 32'(longint'($floor(x * 4294967296.0)));
        end

        reset = 1'b0; s_axis_tdata = 8'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        ref_digest = 128'd0; md5_done = 1'b0; md5_digest = 128'd0; m_axis_tready = 1'b0;
        tick(); tick();
        check_eq("rst_out", out, 4'd0);
        check_eq("rst_block", md5_block, 512'd0);
        check_eq("rst_start", md5_start, 1'b0);
        check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
        check_eq("rst_tdata", m_axis_tdata, 1'b0);
        check_eq("rst_locked", locked, 1'b0);
        check_eq("rst_fail_cnt", fail_cnt, 4'd0);
        reset = 1'b1;
        tick();

        pw = '{8'h61, 8'h62, 8'h63};
        run_attempt(pw, 128'h900150983cd24fb0d6963f7d28e17f72, 0, 1, "abc");
        pw = '{8'h61};
        run_attempt(pw, 128'd0, 0, 0, "one_byte");
        pw = '{8'h31, 8'h32};
        run_attempt(pw, 128'd1, 5, 0, "bp_wrong2");
        pw = '{8'h33};
        run_attempt(pw, 128'd2, 0, 0, "wrong3_lock");

        pw = {};
        for (int i = 0; i < 60; i++) pw.push_back(8'($urandom));
        run_attempt(pw, 128'd0, 0, 0, "ovf60");
        pw = {};
        for (int i = 0; i < 55; i++) pw.push_back(8'($urandom));
        run_attempt(pw, md5_calc(pad_block(pw)), 0, 1, "len55");
        pw.push_back(8'h5a);
        run_attempt(pw, 128'd0, 2, 0, "ovf56");

        pw = '{8'h78};
        ref_digest = 128'd0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h78; s_axis_tlast = 1'b1;
        tick();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        tick();
        check_eq("rstw_in_wait", out, 4'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        md5_digest = 128'd0; md5_done = 1'b1;
        tick();
        md5_done = 1'b0;
        model_fail = 0;
        check_eq("rstw_out", out, 4'd0);
        check_eq("rstw_block", md5_block, 512'd0);
        check_eq("rstw_fail_cnt", fail_cnt, 4'd0);
        check_eq("rstw_locked", locked, 1'b0);
        check_eq("rstw_start", md5_start, 1'b0);
        tick(); tick();
        check_eq("rstw_no_result", m_axis_tvalid, 1'b0);
        check_eq("rstw_idle", out, 4'd0);

        for (int t = 0; t < 40; t++) begin
            pw = {};
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(56, 64) : $urandom_range(1, 55);
            for (int i = 0; i < n; i++) pw.push_back(8'($urandom));
            if (n <= MAX_LEN && $urandom_range(0, 1) == 1) refd = md5_calc(pad_block(pw));
            else refd = {$urandom, $urandom, $urandom, $urandom};
            run_attempt(pw, refd, $urandom_range(0, 3), -1, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
